// File: rtl/isr_vector_dispatcher_if.sv
// Config-bus and CPU-handshake signal bundle for isr_vector_dispatcher.
// The master modport is the firmware/CPU side; the slave modport is the dispatcher.
interface isr_vector_dispatcher_if;
    logic [31:0] intc_write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] intc_read_address;
    logic        read_enable;
    logic [31:0] read_data;
    logic        intr_req;
    logic [31:0] isr_address;
    logic [1:0]  intr_id;
    logic        intr_ack;
    logic        eoi;
    logic        in_service;

    modport master (
        output intc_write_address, write_data, write_enable,
        output intc_read_address, read_enable,
        output intr_ack, eoi,
        input  read_data, intr_req, isr_address, intr_id, in_service
    );

    modport slave (
        input  intc_write_address, write_data, write_enable,
        input  intc_read_address, read_enable,
        input  intr_ack, eoi,
        output read_data, intr_req, isr_address, intr_id, in_service
    );
endinterface

// File: rtl/isr_vector_dispatcher.sv
// Interrupt dispatch block: four ISR address registers on the config bus,
// four latched interrupt sources with fixed priority (bit 0 highest), and a
// request / acknowledge / end-of-interrupt handshake towards the CPU.
// Optional macro INTC_EDGE_DETECT_EN: when defined, sources pend on rising
// edges only; when undefined, sources pend every cycle they are high.
module isr_vector_dispatcher #(
    parameter logic [31:0] DEFAULT_ISR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   irq_in,
    isr_vector_dispatcher_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] isr_reg [4];
    logic [3:0]  pending;
    logic [3:0]  pend_set;
    logic [3:0]  pend_clr;
    logic [1:0]  grant_id;
    logic        grant_fire;
    logic        ack_take;
    logic [1:0]  intr_id_q;
    logic [31:0] isr_addr_q;
    logic [31:0] read_data_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.intc_write_address[31:4], bus.intc_write_address[1:0],
                                bus.intc_read_address[31:5], bus.intc_read_address[1:0]};

    assign grant_fire = (state == IDLE) && (pending != 4'b0000);
    assign ack_take   = (state == REQ) && bus.intr_ack;
    assign pend_clr   = ack_take ? (4'b0001 << intr_id_q) : 4'b0000;

`ifdef INTC_EDGE_DETECT_EN
    logic [3:0] irq_prev;

    // Remember the previous sample of each source for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_prev <= 4'b0000;
        else        irq_prev <= irq_in;
    end

    assign pend_set = irq_in & ~irq_prev;
`else
    assign pend_set = irq_in;
`endif

    // Lowest pending index wins the grant.
    always_comb begin
        grant_id = 2'd0;
        if      (pending[0]) grant_id = 2'd0;
        else if (pending[1]) grant_id = 2'd1;
        else if (pending[2]) grant_id = 2'd2;
        else if (pending[3]) grant_id = 2'd3;
    end

    // Pending latch; an accepted ack clears its bit even if the source is still set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 4'b0000;
        else        pending <= (pending | pend_set) & ~pend_clr;
    end

    // ISR address registers, selected by write address bits [3:2].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) isr_reg[i] <= DEFAULT_ISR;
        end else if (bus.write_enable) begin
            isr_reg[bus.intc_write_address[3:2]] <= bus.write_data;
        end
    end

    // Registered config readback: ISR registers, or the pending vector when bit 4 is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= 32'h0;
        end else if (bus.read_enable) begin
            if (bus.intc_read_address[4]) read_data_q <= {28'h0, pending};
            else                          read_data_q <= isr_reg[bus.intc_read_address[3:2]];
        end
    end

    // Capture id and ISR address at grant so later config writes cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_id_q  <= 2'd0;
            isr_addr_q <= 32'h0;
        end else if (grant_fire) begin
            intr_id_q  <= grant_id;
            isr_addr_q <= isr_reg[grant_id];
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: ack only counts in REQ, eoi only in SVC.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pending != 4'b0000) next_state = REQ;
            REQ:     if (bus.intr_ack)       next_state = SVC;
            SVC:     if (bus.eoi)            next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state register and the captured grant.
    always_comb begin
        bus.intr_req    = (state == REQ);
        bus.in_service  = (state == SVC);
        bus.intr_id     = intr_id_q;
        bus.isr_address = isr_addr_q;
        bus.read_data   = read_data_q;
    end

endmodule

// File: doc/isr_vector_dispatcher.md
# isr_vector_dispatcher

Interrupt-controller dispatch block: holds the four ISR entry addresses written over the INTC config bus, latches up to four interrupt requests, and presents the highest-priority pending request's ISR address to the CPU. The handshake is request, acknowledge, then end-of-interrupt. Config writes are steered by address bits [3:2], the same mapping used by the INTC config write decoder. The block also serves the read side of that config space so firmware can read back ISR addresses and pending state.

## Interface
Parameters:
- `DEFAULT_ISR`, default 32'h0000_0000: reset value of all four ISR address registers.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  4  interrupt sources, synchronous to `clk`; bit 0 has highest priority.
- `intc_write_address`  in  32  config write address; bits [3:2] select ISR register 0..3.
- `write_data`  in  32  config write data.
- `write_enable`  in  1  config write strobe, one write per cycle.
- `intc_read_address`  in  32  config read address.
- `read_enable`  in  1  config read strobe.
- `read_data`  out  32  registered read data.
- `intr_req`  out  1  interrupt request to the CPU.
- `isr_address`  out  32  ISR entry address of the granted source; valid while `intr_req` or `in_service` is high.
- `intr_id`  out  2  granted source index.
- `intr_ack`  in  1  CPU accepts the request.
- `eoi`  in  1  CPU signals end of interrupt.
- `in_service`  out  1  a granted interrupt is being serviced.

## Operation
- **Reset (async, `rst_n` low):**
  - ISR registers = `DEFAULT_ISR`.
  - pending = 4'b0; edge history = 4'b0.
  - State = IDLE.
  - `intr_req` = 0, `in_service` = 0, `intr_id` = 0, `isr_address` = 0, `read_data` = 0.
- **Config write:** when `write_enable`=1, ISR[`intc_write_address`[3:2]] <= `write_data`. The other address bits are ignored.
- **Config read:** when `read_enable`=1, `read_data` <= the selected value; otherwise `read_data` holds. Selection by `intc_read_address`:
  - bit 4 = 0: ISR[addr[3:2]].
  - bit 4 = 1: {28'b0, pending}.
- **Pending set:** bit i is set when source i is asserted (level or edge, see Configuration).
- **Pending clear:** the granted bit is cleared on an accepted `intr_ack`. In that cycle, clear takes priority over set for that bit.
- **State machine:**
  - **IDLE:** if pending != 0, grant the lowest set index. Latch `intr_id` and `isr_address` = ISR[id], go to REQ, and `intr_req` <= 1.
  - **REQ:** `intr_req` = 1 and the outputs are frozen. On `intr_ack`=1: clear pending[id], `intr_req` <= 0, `in_service` <= 1, go to SVC.
  - **SVC:** on `eoi`=1: `in_service` <= 0, go to IDLE.
- No nesting or preemption. A higher-priority source arriving in REQ or SVC only sets its pending bit and is granted after the return to IDLE.
- `intr_ack` outside REQ is ignored. `eoi` outside SVC is ignored.
- A config write to ISR[id] while in REQ or SVC does not change the latched `isr_address`; it takes effect on the next grant.

## Timing
- Config write: visible to a read issued the following cycle. A same-cycle write and read of the same register returns the old value.
- Read latency: 1 cycle (`read_data` valid the cycle after `read_enable`).
- Grant latency:
  - `irq_in` sampled high at edge N -> pending set at N.
  - Grant decision at edge N+1 -> `intr_req`, `intr_id` and `isr_address` valid after edge N+1.
- Ack: `intr_ack` sampled at edge M in REQ -> `intr_req`=0 and `in_service`=1 after M.
- EOI: `eoi` sampled at edge K -> `in_service`=0 after K. If anything is pending, a new grant occurs at K+1 (one idle cycle minimum between interrupts).
- Simultaneous `intr_ack` and `eoi` in REQ: only the ack is honoured; `eoi` is dropped.
- Reset asserted mid-REQ or mid-SVC: all outputs return to their reset values immediately (asynchronous).

## Configuration
- `INTC_EDGE_DETECT_EN`:
  - **Defined:** pending[i] sets only on a rising edge of `irq_in[i]` (current=1, previous sample=0). A source held high yields exactly one interrupt.
  - **Undefined (level mode):** pending[i] sets every cycle `irq_in[i]`=1. A source still high after its ack re-pends on the next cycle, so the ISR must deassert the source before issuing `eoi`.

## Test plan
- **Reset and readback:** write ISR0..3 = 0x100, 0x200, 0x300, 0x400 via addresses 0x20000, 0x20004, 0x20008, 0x2000C -> reads of the same addresses return those values one cycle after `read_enable`.
- **Single interrupt:** `irq_in`=4'b0100 for one cycle -> `intr_req`=1 two edges later with `intr_id`=2 and `isr_address`=0x300. Then `intr_ack` -> `in_service`=1; then `eoi` -> IDLE, pending read = 0.
- **Priority:** `irq_in`=4'b1010 in the same cycle -> first grant id 1 (0x200). After ack and eoi, second grant id 3 (0x400).
- **No preemption:** during SVC for id 3, pulse `irq_in[0]` -> pending read = 4'b0001, `intr_req` stays 0 until `eoi`, then id 0 (0x100) is granted one cycle later.
- **Latched address:** in REQ for id 1, write ISR1 = 0x999 -> `isr_address` stays 0x200 through SVC. The next id 1 grant presents 0x999.
- **Mode and reset:**
  - Hold `irq_in[0]`=1 for 20 cycles with ack and eoi cycled. With `INTC_EDGE_DETECT_EN` defined -> exactly one grant. Undefined -> a re-grant after each eoi.
  - Assert `rst_n`=0 mid-REQ -> `intr_req`=0 immediately.
